// File: rtl/gray_code_source.sv
// Gray-code stimulus source: an up/down binary counter whose Gray encoding is
// registered and streamed downstream over a valid/ready handshake.
module gray_code_source #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic             valid,
  input  logic             ready,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_cnt_q, bin_cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             adv_s;

  // A new word may only be produced when the output slot is empty or being drained.
  always_comb begin
    adv_s = en && !load && (!valid_q || ready);
  end

  // Next-state selection: load beats advance, which beats drain-without-refill.
  always_comb begin
    bin_cnt_d = bin_cnt_q;
    gray_d    = gray_q;
    valid_d   = valid_q;
    wrap_d    = wrap_q;
    if (load) begin
      bin_cnt_d = load_bin;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
    end else if (adv_s) begin
      gray_d    = bin2gray(bin_cnt_q);
      valid_d   = 1'b1;
      if (up_dn) begin
        bin_cnt_d = bin_cnt_q + ONE;
        wrap_d    = (bin_cnt_q == ALL_ONES);
      end else begin
        bin_cnt_d = bin_cnt_q - ONE;
        wrap_d    = (bin_cnt_q == ALL_ZERO);
      end
    end else if (valid_q && ready && !en) begin
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
    end else begin
      valid_d   = valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_q <= ALL_ZERO;
      gray_q    <= ALL_ZERO;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      bin_cnt_q <= bin_cnt_d;
      gray_q    <= gray_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign gray  = gray_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_gray_code_source.sv
// Self-checking bench for gray_code_source: directed scenarios followed by a
// randomized run, all compared against an arithmetic reference model.
module tb_gray_code_source;
  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, up_dn = 1'b1, load = 1'b0, ready = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] gray;
  logic         valid, wrap;

  int errors = 0;
  int checks = 0;

  // reference model state
  int           m_cnt;
  logic [W-1:0] m_gray;
  logic         m_valid, m_wrap;
  logic [W-1:0] prev_word;
  bit           have_prev;
  bit           new_word;

  gray_code_source #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .gray(gray), .valid(valid), .ready(ready), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] g_of(input int b);
    logic [W-1:0] v;
    v = b[W-1:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_gray = '0; m_valid = 1'b0; m_wrap = 1'b0; have_prev = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gray", {28'd0, gray}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: advance the model from the sampled inputs, then compare.
  task automatic cycle();
    bit adv;
    @(posedge clk);
    new_word = 1'b0;
    adv = en && !load && (!m_valid || ready);
    if (load) begin
      m_cnt = int'(load_bin); m_valid = 1'b0; m_wrap = 1'b0; have_prev = 1'b0;
    end else if (adv) begin
      m_gray  = g_of(m_cnt);
      m_valid = 1'b1;
      m_wrap  = up_dn ? (m_cnt == N - 1) : (m_cnt == 0);
      m_cnt   = up_dn ? (m_cnt + 1) % N : (m_cnt + N - 1) % N;
      new_word = 1'b1;
    end else if (m_valid && ready && !en) begin
      m_valid = 1'b0; m_wrap = 1'b0;
    end
    #1;
    chk("gray", {28'd0, gray}, {28'd0, m_gray});
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("wrap", {31'd0, wrap}, {31'd0, m_wrap});
    if (new_word) begin
      if (have_prev) chk("one_bit_step", $countones(gray ^ prev_word), 32'd1);
      prev_word = m_gray;
      have_prev = 1'b1;
    end
  endtask

  logic [W-1:0] seq1 [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                              4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
  logic [W-1:0] seq3 [4] = '{4'b0000, 4'b1000, 4'b1001, 4'b1011};

  initial begin
    // 1: full up-count sweep with wrap
    do_reset();
    en = 1'b1; up_dn = 1'b1; ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cycle();
      chk("t1_seq", {28'd0, gray}, {28'd0, seq1[i]});
      chk("t1_wrap", {31'd0, wrap}, (i == 15) ? 32'd1 : 32'd0);
      chk("t1_bin", g2b(gray), i % N);
      chk("t1_valid", {31'd0, valid}, 32'd1);
    end

    // 2: backpressure at 0011
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    chk("t2_at", {28'd0, gray}, 32'b0011);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_hold_gray", {28'd0, gray}, 32'b0011);
      chk("t2_hold_valid", {31'd0, valid}, 32'd1);
    end
    ready = 1'b1;
    cycle();
    chk("t2_next", {28'd0, gray}, 32'b0010);

    // 4: load while a word is pending
    ready = 1'b0; load = 1'b1; load_bin = 4'b1010;
    cycle();
    chk("t4_drop", {31'd0, valid}, 32'd0);
    load = 1'b0; ready = 1'b1;
    cycle();
    chk("t4_w0", {28'd0, gray}, 32'b1111);
    cycle();
    chk("t4_w1", {28'd0, gray}, 32'b1110);

    // 5: en low for three cycles, then resume
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_idle_valid", {31'd0, valid}, 32'd0);
    end
    en = 1'b1;
    cycle();
    chk("t5_resume", {28'd0, gray}, 32'b1010);

    // 3: down count from reset
    do_reset();
    up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_seq", {28'd0, gray}, {28'd0, seq3[i]});
      chk("t3_wrap", {31'd0, wrap}, (i == 0) ? 32'd1 : 32'd0);
    end

    // 6: asynchronous reset mid-cycle
    up_dn = 1'b1;
    cycle(); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gray", {28'd0, gray}, 32'd0);
    chk("t6_valid", {31'd0, valid}, 32'd0);
    chk("t6_wrap", {31'd0, wrap}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("t6_first", {28'd0, gray}, 32'd0);
    chk("t6_first_valid", {31'd0, valid}, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(3, 0) != 0);
      up_dn    = ($urandom_range(7, 0) != 0) ? up_dn : ~up_dn;
      ready    = ($urandom_range(2, 0) != 0);
      load     = ($urandom_range(15, 0) == 0);
      load_bin = W'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
